// File: rtl/program_sequencer.sv
// ============================================================================
//  Module   : program_sequencer
//  Purpose  : Fetch-address generator with jump redirect, core reset, flush
//             and a saturating taken-jump counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module program_sequencer #(
  parameter int unsigned          PM_ADDR_W    = 8,
  parameter logic [PM_ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned          CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 sync_reset_n,
  input  logic                 jmp,
  input  logic                 jmp_nz,
  input  logic                 dont_jmp,
  input  logic [PM_ADDR_W-1:0] jmp_addr,
  input  logic                 hold,
  output logic [PM_ADDR_W-1:0] pm_addr,
  output logic [PM_ADDR_W-1:0] pc,
  output logic                 core_reset,
  output logic                 flush,
  output logic [CNT_W-1:0]     jmp_count
);

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_BOOT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [PM_ADDR_W-1:0] pc_q;
  logic [PM_ADDR_W-1:0] pc_d;
  logic                 core_reset_q;
  logic                 core_reset_d;
  logic                 flush_q;
  logic                 flush_d;
  logic [CNT_W-1:0]     jmp_count_q;
  logic [CNT_W-1:0]     jmp_count_d;
  logic                 taken;

  // jmp wins over jmp_nz simply because the OR already makes it taken.
  assign taken = (state_q == ST_RUN) & (jmp | (jmp_nz & ~dont_jmp));

  always_comb begin
    state_d = ST_RST;
    if (sync_reset_n) begin
      case (state_q)
        ST_RST:  state_d = ST_BOOT;
        ST_BOOT: state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_RST;
      endcase
    end
  end

  always_comb begin
    pc_d = RESET_VECTOR;
    case (state_q)
      ST_RST:  pc_d = RESET_VECTOR;
      ST_BOOT: pc_d = RESET_VECTOR + PM_ADDR_W'(1);
      ST_RUN: begin
        if (taken)
          pc_d = jmp_addr;
        else if (hold)
          pc_d = pc_q;
        else
          pc_d = pc_q + PM_ADDR_W'(1);
      end
      default: pc_d = RESET_VECTOR;
    endcase
  end

  // core_reset tracks the next state so it drops together with entry into RUN.
  assign core_reset_d = (state_d != ST_RUN);
  assign flush_d      = taken;

  always_comb begin
    jmp_count_d = jmp_count_q;
    if (taken && !(&jmp_count_q))
      jmp_count_d = jmp_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state_q      <= ST_RST;
      pc_q         <= RESET_VECTOR;
      core_reset_q <= 1'b1;
      flush_q      <= 1'b0;
      jmp_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      core_reset_q <= core_reset_d;
      flush_q      <= flush_d;
      jmp_count_q  <= jmp_count_d;
    end
  end

  assign pm_addr    = pc_d;
  assign pc         = pc_q;
  assign core_reset = core_reset_q;
  assign flush      = flush_q;
  assign jmp_count  = jmp_count_q;

endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
// ============================================================================
//  Module   : tb_program_sequencer
//  Purpose  : Directed vector bench for program_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       sync_reset_n;
  logic       jmp;
  logic       jmp_nz;
  logic       dont_jmp;
  logic [7:0] jmp_addr;
  logic       hold;
  logic [7:0] pm_addr;
  logic [7:0] pc;
  logic       core_reset;
  logic       flush;
  logic [7:0] jmp_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  program_sequencer #(
    .PM_ADDR_W   (8),
    .RESET_VECTOR(8'h00),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .sync_reset_n(sync_reset_n),
    .jmp         (jmp),
    .jmp_nz      (jmp_nz),
    .dont_jmp    (dont_jmp),
    .jmp_addr    (jmp_addr),
    .hold        (hold),
    .pm_addr     (pm_addr),
    .pc          (pc),
    .core_reset  (core_reset),
    .flush       (flush),
    .jmp_count   (jmp_count)
  );

  typedef struct {
    logic       rst_n;
    logic       jmp;
    logic       jmp_nz;
    logic       dont_jmp;
    logic       hold;
    logic [7:0] addr;
    logic [7:0] e_pm;
    logic [7:0] e_pc;
    logic       e_cr;
    logic       e_fl;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic j, input logic jn, input logic dj, input logic h,
                       input logic [7:0] a);
    sync_reset_n = r;
    jmp          = j;
    jmp_nz       = jn;
    dont_jmp     = dj;
    hold         = h;
    jmp_addr     = a;
  endtask

  initial begin
    // Each row: inputs applied for one cycle; expected values seen mid-cycle.
    //              rst jmp jnz dnt hld addr   pm     pc    cr    fl    cnt
    vecs.push_back('{0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'd0});
    vecs.push_back('{0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'd0});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'd0});
    vecs.push_back('{1, 1, 0, 0, 1, 8'h55, 8'h01, 8'h00, 1'b1, 1'b0, 8'd0});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h02, 8'h01, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h03, 8'h02, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1, 1, 0, 0, 0, 8'hFD, 8'hFD, 8'h03, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 8'hFE, 8'hFD, 1'b0, 1'b1, 8'd1});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 8'hFF, 8'hFE, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{1, 1, 0, 0, 0, 8'h10, 8'h10, 8'h01, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{1, 1, 0, 0, 0, 8'h3C, 8'h3C, 8'h10, 1'b0, 1'b1, 8'd2});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h3D, 8'h3C, 1'b0, 1'b1, 8'd3});
    vecs.push_back('{1, 0, 1, 1, 0, 8'h80, 8'h3E, 8'h3D, 1'b0, 1'b0, 8'd3});
    vecs.push_back('{1, 0, 1, 0, 0, 8'h80, 8'h80, 8'h3E, 1'b0, 1'b0, 8'd3});
    vecs.push_back('{1, 1, 1, 1, 0, 8'h22, 8'h22, 8'h80, 1'b0, 1'b1, 8'd4});
    vecs.push_back('{1, 0, 0, 0, 1, 8'h00, 8'h22, 8'h22, 1'b0, 1'b1, 8'd5});
    vecs.push_back('{1, 0, 0, 0, 1, 8'h00, 8'h22, 8'h22, 1'b0, 1'b0, 8'd5});
    vecs.push_back('{1, 0, 0, 0, 1, 8'h00, 8'h22, 8'h22, 1'b0, 1'b0, 8'd5});
    vecs.push_back('{1, 0, 0, 0, 1, 8'h00, 8'h22, 8'h22, 1'b0, 1'b0, 8'd5});
    vecs.push_back('{1, 1, 0, 0, 1, 8'h05, 8'h05, 8'h22, 1'b0, 1'b0, 8'd5});
    vecs.push_back('{0, 1, 0, 0, 0, 8'h40, 8'h40, 8'h05, 1'b0, 1'b1, 8'd6});
    vecs.push_back('{0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'd0});
    vecs.push_back('{1, 1, 0, 0, 0, 8'h99, 8'h00, 8'h00, 1'b1, 1'b0, 8'd0});
    vecs.push_back('{1, 0, 1, 0, 0, 8'h77, 8'h01, 8'h00, 1'b1, 1'b0, 8'd0});
    vecs.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h02, 8'h01, 1'b0, 1'b0, 8'd0});

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);

    foreach (vecs[i]) begin
      #1;
      drive(vecs[i].rst_n, vecs[i].jmp, vecs[i].jmp_nz, vecs[i].dont_jmp, vecs[i].hold, vecs[i].addr);
      @(negedge clk);
      check("pm_addr",    i, pm_addr,           vecs[i].e_pm);
      check("pc",         i, pc,                vecs[i].e_pc);
      check("core_reset", i, {7'd0, core_reset}, {7'd0, vecs[i].e_cr});
      check("flush",      i, {7'd0, flush},      {7'd0, vecs[i].e_fl});
      check("jmp_count",  i, jmp_count,         vecs[i].e_cnt);
      @(posedge clk);
    end

    // Saturation: 256 back-to-back taken jumps starting from a cleared counter.
    for (int k = 0; k < 256; k++) begin
      logic [7:0] tgt;
      logic [7:0] exp_cnt;
      tgt = 8'(k);
      exp_cnt = 8'(k);
      #1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tgt);
      @(negedge clk);
      check("sat_pm_addr", 100 + k, pm_addr, tgt);
      if (k == 0 || k == 254 || k == 255)
        check("sat_count", 100 + k, jmp_count, exp_cnt);
      if (k > 0)
        check("sat_flush", 100 + k, {7'd0, flush}, 8'd1);
      @(posedge clk);
    end
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("sat_final_count", 400, jmp_count, 8'hFF);
    check("sat_final_pc",    401, pc,        8'hFF);
    check("sat_final_pm",    402, pm_addr,   8'h00);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12);
    @(negedge clk);
    check("sat_flush_low", 403, {7'd0, flush}, 8'd0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("sat_hold_count", 404, jmp_count, 8'hFF);
    check("sat_jump_pc",    405, pc,        8'h12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
